viterbi_bmu_pipe: RTL and testbench
===================================

Name: viterbi_bmu_pipe

Overview:
Parametrised, pipelined branch metric unit for the Viterbi decoder datapath. It generalises the fixed rate-1/2 hard-decision BMU to N code bits per symbol and Q-bit soft input, with a selectable hard or soft metric and per-bit erasure for punctured codes. It computes the metric for all 2^N codewords, not per state, so the ACS stage indexes metrics by the branch label. It sits between the depuncturer/demapper and the ACS array, with valid/ready handshakes on both sides.

Parameters:
N, 2, code bits per symbol (1/N code rate); legal range 1..4
Q, 3, soft-value width; unsigned offset-binary, 0 = strong '0', 2^Q-1 = strong '1'; legal 1..6
CW, 16, width of the symbol-in-frame counter
MW (localparam), clog2(N*(2^Q-1)+1), metric width; 4 for N=2, Q=3

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input symbol valid
in_ready  out  1  block accepts the input symbol this cycle
in_sym  in  N*Q  soft value of code bit i at [i*Q +: Q]
in_erase  in  N  bit i = 1: code bit i is punctured and contributes 0
in_last  in  1  last symbol of frame
mode  in  1  0 = hard (Hamming), 1 = soft (L1); sampled with the symbol
out_valid  out  1  metrics valid
out_ready  in  1  downstream accepts
out_bm  out  (2^N)*MW  metric for codeword c at [c*MW +: MW]; bit i of codeword = c[i]
out_min_idx  out  N  codeword with the smallest metric; ties go to the lowest index
out_last  out  1  in_last delayed with the symbol
out_sym_idx  out  CW  index of this symbol within the frame

Behaviour:
- Reset (async assert, sync release): s1_valid, s2_valid, out_valid, out_bm, out_min_idx, out_last, out_sym_idx and the frame counter all clear to 0. A reset mid-frame drops all in-flight symbols, and the counter restarts at 0.
- Handshake: a transfer occurs when valid and ready are both 1.
  - s2_load = !s2_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load (combinational; no dependency on in_valid)
  - Output fields stay stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input acceptance to out_valid when there is no stall. Throughput is 1 symbol/cycle with out_ready held at 1. No bubbles are inserted and no symbols are dropped or duplicated under any out_ready pattern.
- Stage 1 (registered on accept):
  - Per-bit distances d0[i] (to '0') and d1[i] (to '1').
  - Hard mode: h = MSB of v; d0 = h, d1 = !h (values 0/1).
  - Soft mode: d0 = v, d1 = (2^Q-1) - v.
  - Erased bit: d0 = d1 = 0.
  - Stage 1 also captures in_last and the current frame counter value.
- Stage 2 (registered on s2_load):
  - bm[c] = sum over i of (c[i] ? d1[i] : d0[i]), zero-extended to MW. No saturation is needed because MW covers the maximum.
  - out_min_idx comes from a strict-less-than compare in ascending c order.
- Frame counter:
  - Increments on each input accept and wraps at 2^CW.
  - Reset to 0 on accept of a symbol with in_last=1; that symbol carries the pre-reset index.
  - in_last and wrap on the same symbol: the counter goes to 0.
- mode may change every symbol. Each symbol uses the mode sampled at its own accept.
- All bits erased: all metrics are 0 and out_min_idx = 0.

Test Plan:
- Hard, N=2, Q=3: in_sym v0=7, v1=0, no erase -> out_bm = {c0:1, c1:0, c2:2, c3:1}, out_min_idx=1, out_valid exactly 2 cycles after accept.
- Soft: v0=5, v1=2 -> {c0:7, c1:4, c2:10, c3:7}, out_min_idx=1. Same input in hard mode -> {1, 0, 2, 1}.
- Erasure: v0=5, in_erase=2'b10, soft -> {5, 2, 5, 2}, min_idx=1. in_erase=2'b11 -> all 0, min_idx=0.
- Backpressure: stream 8 symbols with in_last on the 4th; out_ready pattern 1,0,0,1,0,1,1,... -> in_ready drops only when both stages are full. All 8 symbols come out in order and unchanged. out_sym_idx = 0,1,2,3,0,1,2,3, with out_last on the 4th and 8th.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 immediately (asynchronous). After release, the first new symbol has out_sym_idx=0.
- Extremes: N=2, Q=3, soft, v0=v1=0 -> c3 metric=14 (fits MW=4). v0=v1=7 -> c0=14, min_idx=3.

Source files
------------

// File: rtl/viterbi_bmu_pipe.sv
// Two-stage branch metric unit: per-bit distances to '0'/'1', then the metric of
// every codeword plus the index of the lowest. Valid/ready on both sides.

module viterbi_bmu_dist #(
  parameter int Q = 3
) (
  input  logic [Q-1:0] v,
  input  logic         erase,
  input  logic         mode,
  output logic [Q-1:0] d0,
  output logic [Q-1:0] d1
);
  always_comb begin
    d0 = '0;
    d1 = '0;
    if (!erase) begin
      if (mode) begin
        d0 = v;
        d1 = ~v;                  // (2^Q-1) - v in Q bits
      end else begin
        d0 = Q'(v[Q-1]);
        d1 = Q'(!v[Q-1]);
      end
    end
  end
endmodule

module viterbi_bmu_pipe #(
  parameter  int N  = 2,
  parameter  int Q  = 3,
  parameter  int CW = 16,
  localparam int NC = 1 << N,
  localparam int MW = $clog2(N * ((1 << Q) - 1) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*Q-1:0]    in_sym,
  input  logic [N-1:0]      in_erase,
  input  logic              in_last,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NC*MW-1:0]  out_bm,
  output logic [N-1:0]      out_min_idx,
  output logic              out_last,
  output logic [CW-1:0]     out_sym_idx
);
  logic s1_valid, s2_valid, s1_load, s2_load;
  logic [N-1:0][Q-1:0] d0, d1, d0_q, d1_q;
  logic s1_last;
  logic [CW-1:0] s1_idx, cnt;
  logic [NC-1:0][MW-1:0] bm;
  logic [N-1:0] min_idx;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  viterbi_bmu_dist #(.Q(Q)) u_dist [N-1:0] (
    .v(in_sym), .erase(in_erase), .mode(mode), .d0(d0), .d1(d1)
  );

  // Metrics for all codewords; bit i of c picks the distance to '1' for code bit i.
  always_comb begin
    bm = '0;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < N; i++)
        bm[c] = bm[c] + (((c >> i) & 1) != 0 ? MW'(d1_q[i]) : MW'(d0_q[i]));
    min_idx = '0;
    for (int c = 1; c < NC; c++)
      if (bm[c] < bm[min_idx]) min_idx = N'(c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      d0_q     <= '0;
      d1_q     <= '0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      cnt      <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        d0_q    <= d0;
        d1_q    <= d1;
        s1_last <= in_last;
        s1_idx  <= cnt;
        cnt     <= in_last ? '0 : cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      out_bm      <= '0;
      out_min_idx <= '0;
      out_last    <= 1'b0;
      out_sym_idx <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_bm      <= bm;
        out_min_idx <= min_idx;
        out_last    <= s1_last;
        out_sym_idx <= s1_idx;
      end
    end
  end
endmodule

// File: tb/tb_viterbi_bmu_pipe.sv
// Randomized and directed bench for viterbi_bmu_pipe against a queue-based
// behavioural model of codeword metrics and frame indexing.

module tb_viterbi_bmu_pipe;
  localparam int N    = 2;
  localparam int Q    = 3;
  localparam int CW   = 4;
  localparam int NC   = 1 << N;
  localparam int VMAX = (1 << Q) - 1;
  localparam int MW   = $clog2(N * VMAX + 1);

  logic clk, rst_n;
  logic in_valid, in_ready, in_last, mode, out_valid, out_ready, out_last;
  logic [N*Q-1:0]   in_sym;
  logic [N-1:0]     in_erase, out_min_idx;
  logic [NC*MW-1:0] out_bm;
  logic [CW-1:0]    out_sym_idx;

  viterbi_bmu_pipe #(.N(N), .Q(Q), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .in_erase(in_erase), .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_bm(out_bm),
    .out_min_idx(out_min_idx), .out_last(out_last), .out_sym_idx(out_sym_idx)
  );

  typedef struct {
    logic [NC*MW-1:0] bm;
    logic [N-1:0]     mn;
    logic             last;
    logic [CW-1:0]    idx;
  } exp_t;

  exp_t q[$];
  int   lg_idx[$];
  int   lg_last[$];
  int   cnt = 0;
  int   errors = 0, checks = 0;
  int   rdy_sel = 0, pi = 0;
  logic [0:15] pat = 16'b1001011000100111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: metric = sum of distances from each soft value to the codeword bit.
  function automatic exp_t model(input logic [N*Q-1:0] s, input logic [N-1:0] e,
                                 input logic m, input logic l, input int idx);
    exp_t r;
    int met[NC];
    int v, best;
    r.bm = '0;
    for (int c = 0; c < NC; c++) begin
      met[c] = 0;
      for (int i = 0; i < N; i++) begin
        v = int'(s[i*Q +: Q]);
        if (e[i]) continue;
        if (m) met[c] += ((c >> i) & 1) != 0 ? VMAX - v : v;
        else   met[c] += ((c >> i) & 1) != 0 ? 1 - (v >> (Q-1)) : (v >> (Q-1));
      end
      r.bm[c*MW +: MW] = MW'(met[c]);
    end
    best = 0;
    for (int c = 1; c < NC; c++) if (met[c] < met[best]) best = c;
    r.mn   = N'(best);
    r.last = l;
    r.idx  = CW'(idx);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          chk("bm", out_bm, q[0].bm);
          chk("min_idx", out_min_idx, q[0].mn);
          chk("last", out_last, q[0].last);
          chk("sym_idx", out_sym_idx, q[0].idx);
          if (out_ready) begin
            lg_idx.push_back(int'(out_sym_idx));
            lg_last.push_back(int'(out_last));
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_sym, in_erase, mode, in_last, cnt));
        cnt = in_last ? 0 : (cnt + 1) % (1 << CW);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_sel)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[pi]; if (pi < 15) pi++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N*Q-1:0] s, input logic [N-1:0] e, input logic m, input logic l);
    logic acc;
    int   k = 0;
    in_sym = s; in_erase = e; mode = m; in_last = l; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); k++;
    end while (!acc && k < 1000);
    if (!acc) chk("send_timeout", acc, 1'b1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    rdy_sel = 0;
    while (q.size() != 0 && k < 50) begin @(posedge clk); k++; end
    #1 chk("drain", q.size(), 0);
  endtask

  task automatic dir(input string tag, input logic [N*Q-1:0] s, input logic [N-1:0] e,
                     input logic m, input logic [NC*MW-1:0] ebm, input logic [N-1:0] emin);
    send(s, e, m, 1'b0);
    chk({tag, "_lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_bm"}, out_bm, ebm);
    chk({tag, "_min"}, out_min_idx, emin);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sym = '0; in_erase = '0; in_last = 1'b0; mode = 1'b0;
    #1;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_bm", out_bm, '0);
    chk("rst_min", out_min_idx, '0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_idx", out_sym_idx, '0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Backpressure stream with frame boundary on 4th and 8th symbol.
    lg_idx.delete(); lg_last.delete();
    pi = 0; rdy_sel = 1;
    for (int k = 0; k < 8; k++)
      send((N*Q)'($urandom), '0, 1'($urandom), (k == 3) || (k == 7));
    drain();
    chk("bp_count", lg_idx.size(), 8);
    for (int k = 0; k < 8 && k < lg_idx.size(); k++) begin
      chk("bp_idx", lg_idx[k], k % 4);
      chk("bp_last", lg_last[k], (k == 3) || (k == 7));
    end

    // Directed metric cases: in_sym = {v1, v0}.
    dir("hard70",  6'o07, 2'b00, 1'b0, 16'h1201, 2'd1);
    dir("soft52",  6'o25, 2'b00, 1'b1, 16'h7A47, 2'd1);
    dir("hard52",  6'o25, 2'b00, 1'b0, 16'h1201, 2'd1);
    dir("erase10", 6'o05, 2'b10, 1'b1, 16'h2525, 2'd1);
    dir("erase11", 6'o25, 2'b11, 1'b1, 16'h0000, 2'd0);
    dir("soft00",  6'o00, 2'b00, 1'b1, 16'hE770, 2'd0);
    dir("soft77",  6'o77, 2'b00, 1'b1, 16'h077E, 2'd3);

    // Asynchronous reset with both stages full.
    rdy_sel = 3;
    @(posedge clk); #1; @(posedge clk); #1;
    send((N*Q)'($urandom), '0, 1'b1, 1'b0);
    send((N*Q)'($urandom), '0, 1'b1, 1'b0);
    chk("full_in_ready", in_ready, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("rst_async_vld", out_valid, 1'b0);
    q.delete(); cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1; rdy_sel = 0;
    send((N*Q)'($urandom), '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_vld", out_valid, 1'b1);
    chk("post_rst_idx", out_sym_idx, '0);
    drain();

    // Random traffic with random backpressure, gaps, erasures and frame ends.
    rdy_sel = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      else send((N*Q)'($urandom),
                ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                1'($urandom), $urandom_range(0, 5) == 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
